// File: rtl/mips_fetch_stage.sv
// ============================================================================
// mips_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the classic 5-stage MIPS pipeline.
//
// The stage owns the program counter and presents it to a combinational
// instruction memory. The returned word is captured, together with PC+4,
// into the IF/ID pipeline register. Later stages can hold the front end
// (stall), squash the IF/ID contents (flush) or redirect the fetch stream
// (EX-stage branch, ID-stage jump). A free-running counter of instructions
// actually delivered to decode is kept for bring-up and debug.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous active-high reset
//   pc             out  32     current fetch address (to instruction memory)
//   imem_rd        in   32     instruction word for pc (combinational)
//   stall          in   1      hazard-unit hold; freezes PC and IF/ID
//   flush          in   1      squash IF/ID on the next edge
//   branch_taken   in   1      EX-stage branch redirect request
//   branch_target  in   32     branch redirect address
//   jump           in   1      ID-stage jump redirect request
//   jump_target    in   32     jump redirect address
//   if_id_instr    out  32     registered instruction handed to decode
//   if_id_pc_plus4 out  32     registered PC+4 of that instruction
//   if_id_valid    out  1      IF/ID holds a real instruction (0 = bubble)
//   misalign_err   out  1      sticky flag: a used redirect target was
//                              not word aligned
//   fetch_count    out  CNT_W  valid instructions loaded into IF/ID (wraps)
// ============================================================================
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      pc,
    input  logic [31:0]      imem_rd,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      instr_q,     instr_d;
    logic [31:0]      pcPlus4_q,   pcPlus4_d;
    logic             valid_q,     valid_d;
    logic             misalign_q,  misalign_d;
    logic [CNT_W-1:0] count_q,     count_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [31:0] pcPlus4;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] alignedTarget;
    logic        loadIfId;

    // Sequential fetch address; natural 32-bit wrap takes 0xFFFF_FFFC to 0.
    assign pcPlus4 = pc_q + 32'd4;

    // Pick the redirect source. The branch sits in EX and is therefore older
    // than the jump in ID, so it wins when both fire in the same cycle.
    always_comb begin
        redirect       = branch_taken | jump;
        redirectTarget = branch_taken ? branch_target : jump_target;
        alignedTarget  = {redirectTarget[31:2], 2'b00};
    end

    // Next PC. Redirects beat stall: a stalled front end still has to leave
    // the wrong path, otherwise the redirect would be lost.
    always_comb begin
        pc_d = pcPlus4;
        if (redirect) begin
            pc_d = alignedTarget;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state. A flush or redirect discards the word currently
    // being fetched (it is on the wrong path) and inserts a NOP bubble, even
    // while stalled. Only a genuine load counts as a delivered instruction.
    always_comb begin
        instr_d   = instr_q;
        pcPlus4_d = pcPlus4_q;
        valid_d   = valid_q;
        loadIfId  = 1'b0;
        if (flush || redirect) begin
            instr_d   = 32'd0;
            pcPlus4_d = 32'd0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            instr_d   = imem_rd;
            pcPlus4_d = pcPlus4;
            valid_d   = 1'b1;
            loadIfId  = 1'b1;
        end
    end

    // Bring-up counter and sticky misalignment flag. The flag only looks at
    // the target that is actually selected, so a misaligned jump target that
    // loses to a branch does not raise it.
    always_comb begin
        count_d    = loadIfId ? count_q + 1'b1 : count_q;
        misalign_d = misalign_q;
        if (redirect && (redirectTarget[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    // All stage state lives here and returns to its reset values as soon as
    // reset is raised, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pcPlus4_q  <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcPlus4_q  <= pcPlus4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pcPlus4_q;
    assign if_id_valid    = valid_q;
    assign misalign_err   = misalign_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// ============================================================================
// tb_mips_fetch_stage
// ----------------------------------------------------------------------------
// Self-checking bench for mips_fetch_stage: a directed vector table, a few
// hand-written multi-cycle sequences (async reset mid-run) and a randomized
// run compared against a behavioural model of the fetch stage.
// ============================================================================
module tb_mips_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 16;

    logic             clk;
    logic             reset;
    logic [31:0]      pc;
    logic [31:0]      imem_rd;
    logic             stall;
    logic             flush;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc_plus4;
    logic             if_id_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [31:0]      mPc;
    logic [31:0]      mInstr;
    logic [31:0]      mPc4;
    logic             mValid;
    logic             mErr;
    logic [CNT_W-1:0] mCnt;

    typedef struct {
        logic             st;
        logic             fl;
        logic             br;
        logic [31:0]      bt;
        logic             jp;
        logic [31:0]      jt;
        logic [31:0]      expPc;
        logic [31:0]      expInstr;
        logic [31:0]      expPc4;
        logic             expValid;
        logic             expErr;
        logic [CNT_W-1:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    mips_fetch_stage #(
        .RESET_PC(RESET_PC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .imem_rd       (imem_rd),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    // Instruction memory contents: two fixed words at 0 and 4, a simple
    // address-derived pattern everywhere else.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2008_0005;
        else if (a == 32'h4) return 32'h2009_0007;
        else                 return a ^ 32'h3C00_BEEF;
    endfunction

    assign imem_rd = memWord(pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with pass/fail bookkeeping
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Compare every DUT output against the given expectations
    task automatic checkOutput(input string tag,
                               input logic [31:0] ePc, input logic [31:0] eInstr,
                               input logic [31:0] ePc4, input logic eValid,
                               input logic eErr, input logic [CNT_W-1:0] eCnt);
        check32({tag, ".pc"},          pc,                     ePc);
        check32({tag, ".instr"},       if_id_instr,            eInstr);
        check32({tag, ".pc_plus4"},    if_id_pc_plus4,         ePc4);
        check32({tag, ".valid"},       {31'd0, if_id_valid},   {31'd0, eValid});
        check32({tag, ".misalign"},    {31'd0, misalign_err},  {31'd0, eErr});
        check32({tag, ".fetch_count"}, {16'd0, fetch_count},   {16'd0, eCnt});
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, mPc, mInstr, mPc4, mValid, mErr, mCnt);
    endtask

    task automatic modelReset();
        mPc    = RESET_PC;
        mInstr = 32'd0;
        mPc4   = 32'd0;
        mValid = 1'b0;
        mErr   = 1'b0;
        mCnt   = '0;
    endtask

    // One clock edge of the fetch stage described in terms of its rules:
    // which address is fetched next, what decode sees, what gets counted.
    task automatic modelEdge(input logic st, input logic fl, input logic br,
                             input logic [31:0] bt, input logic jp, input logic [31:0] jt);
        logic [31:0] target;
        logic        redir;
        redir  = br || jp;
        target = br ? bt : jt;
        if (redir && (target % 4 != 0)) mErr = 1'b1;
        if (fl || redir) begin
            mInstr = 32'd0;
            mPc4   = 32'd0;
            mValid = 1'b0;
        end else if (!st) begin
            mInstr = memWord(mPc);
            mPc4   = mPc + 32'd4;
            mValid = 1'b1;
            mCnt   = mCnt + 1'b1;
        end
        if (redir)    mPc = target - (target % 4);
        else if (!st) mPc = mPc + 32'd4;
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 ns after
    // the rising edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic br,
                                 input logic [31:0] bt, input logic jp, input logic [31:0] jt);
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        modelEdge(st, fl, br, bt, jp, jt);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Directed table: each row is the inputs held across one edge and
        // the outputs expected right after it.
        //            st fl br bt             jp jt            pc             instr                    pc4            v  e  cnt
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        32'h2008_0005,           32'h4,         1, 0, 16'd1});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h2009_0007,           32'h8,         1, 0, 16'd2});
        vecs.push_back('{1, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h2009_0007,           32'h8,         1, 0, 16'd2});
        vecs.push_back('{1, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h2009_0007,           32'h8,         1, 0, 16'd2});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'hC,        memWord(32'h8),          32'hC,         1, 0, 16'd3});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h10,       memWord(32'hC),          32'h10,        1, 0, 16'd4});
        vecs.push_back('{0, 0, 1, 32'h40,       0, 32'h0,       32'h40,       32'h0,                   32'h0,         0, 0, 16'd4});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h44,       memWord(32'h40),         32'h44,        1, 0, 16'd5});
        vecs.push_back('{1, 0, 1, 32'h80,       1, 32'h100,     32'h80,       32'h0,                   32'h0,         0, 0, 16'd5});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h84,       memWord(32'h80),         32'h84,        1, 0, 16'd6});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h102,     32'h100,      32'h0,                   32'h0,         0, 1, 16'd6});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h104,      memWord(32'h100),        32'h104,       1, 1, 16'd7});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 32'h0,       32'h108,      32'h0,                   32'h0,         0, 1, 16'd7});
        vecs.push_back('{0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,      32'hFFFF_FFFC, 32'h0,                  32'h0,         0, 1, 16'd7});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h0,        memWord(32'hFFFF_FFFC),  32'h0,         1, 1, 16'd8});
        vecs.push_back('{1, 1, 0, 32'h0,        0, 32'h0,       32'h0,        32'h0,                   32'h0,         0, 1, 16'd8});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        32'h2008_0005,           32'h4,         1, 1, 16'd9});

        // Reset values
        doReset();
        checkOutput("reset", RESET_PC, 32'd0, 32'd0, 1'b0, 1'b0, '0);

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt);
            checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expInstr,
                        vecs[i].expPc4, vecs[i].expValid, vecs[i].expErr, vecs[i].expCnt);
        end

        // Asynchronous reset between edges at pc = 0x20 with valid IF/ID
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("preRst", 32'h20, memWord(32'h1C), 32'h20, 1'b1, 1'b0, 16'd8);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncRst", RESET_PC, 32'd0, 32'd0, 1'b0, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("postRst", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0, 16'd1);

        // Randomized run against the behavioural model
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic        st, fl, br, jp;
            logic [31:0] bt, jt;
            st = ($urandom % 4) == 0;
            fl = ($urandom % 8) == 0;
            br = ($urandom % 10) == 0;
            jp = ($urandom % 10) == 0;
            bt = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            jt = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 40 == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom % 40 == 0) jt[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(st, fl, br, bt, jp, jt);
            checkModel($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the PC to the combinational instruction memory.
- Captures the returned word together with PC+4 into the IF/ID pipeline register.
- Handles stall, flush, and branch/jump redirects from later stages, and keeps a retired-fetch counter for bring-up.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pc  output  32  current fetch address; drives instruction memory address.
- imem_rd  input  32  instruction word returned combinationally for pc.
- stall  input  1  hazard-unit hold (load-use); freezes PC and IF/ID.
- flush  input  1  squash IF/ID contents next edge.
- branch_taken  input  1  EX-stage branch redirect.
- branch_target  input  32  redirect address for branch.
- jump  input  1  ID-stage jump redirect.
- jump_target  input  32  redirect address for jump.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- misalign_err  output  1  sticky: a redirect target had addr[1:0] != 0.
- fetch_count  output  CNT_W  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset values (immediate on reset assertion, independent of clk):
  - pc = RESET_PC, if_id_instr = 0 (NOP), if_id_pc_plus4 = 0, if_id_valid = 0, misalign_err = 0, fetch_count = 0.
- pc_plus4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Next-PC priority, highest first:
  1. branch_taken: next = {branch_target[31:2], 2'b00}.
  2. jump: next = {jump_target[31:2], 2'b00}.
  3. stall: next = pc (hold).
  4. Otherwise: next = pc_plus4.
- Redirects override stall. An older branch in EX beats a younger jump in ID.
- Redirect = branch_taken | jump.
- IF/ID update on each rising edge, highest first:
  1. flush or redirect: if_id_valid <= 0, if_id_instr <= 0, if_id_pc_plus4 <= 0. The wrong-path word is discarded; this overrides stall.
  2. stall: all IF/ID fields hold.
  3. Otherwise: if_id_instr <= imem_rd, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
- Latency: instruction at address A appears on if_id_instr one edge after pc == A with no stall. The redirect penalty is one bubble.
- fetch_count increments by 1 on each edge taking the IF/ID "otherwise" path. It wraps at 2^CNT_W.
- misalign_err sets when the selected redirect target has nonzero [1:0] on an edge where it is used. It clears only on reset.
- The target is still force-aligned; execution continues.
- Reset asserted mid-run: all state returns to reset values asynchronously. The first fetch after release is at RESET_PC.
- No combinational path from stall/flush/redirect inputs to pc. All outputs are registered.

Test Plan:
- Reset release, memory holds 0x20080005 at 0, 0x20090007 at 4 → three edges give pc = 4, 8, 12.
  - First IF/ID: instr 0x20080005, pc_plus4 4, valid 1.
  - Second IF/ID: instr 0x20090007, pc_plus4 8.
  - fetch_count = 3.
- stall high for 2 cycles at pc = 8 → pc stays 8 and IF/ID holds instr from 4 for both cycles. After release, pc = 12 next edge. fetch_count does not increment while stalled.
- branch_taken = 1, branch_target = 0x40 while pc = 0x10 → next edge: pc = 0x40, if_id_valid = 0, if_id_instr = 0. Following edge: IF/ID holds word from 0x40 with pc_plus4 0x44.
- branch_taken (target 0x80) and jump (target 0x100) and stall all high in the same cycle → pc = 0x80 and IF/ID is a bubble.
- jump_target = 0x102 → pc = 0x100 and misalign_err = 1. It remains 1 after later normal fetches until reset.
- Assert reset asynchronously between edges at pc = 0x20 with valid IF/ID → outputs return to reset values immediately. After release, first IF/ID is the word from RESET_PC.
- Set pc to 0xFFFF_FFFC via branch → next sequential pc = 0.
